buffer_rr_mux: RTL and testbench
================================

// Module: buffer_rr_mux
// PURPOSE
// - N-channel successor to the two-enable bus buffer: NUM_CH sources, each with an enable and a data word, share one registered output.
// - Simultaneous enables are resolved by a round-robin arbiter instead of bus contention. Output uses a valid/ready handshake.
// - Sits between multiple producers and one downstream consumer; one beat is transferred per granted request.
// PARAMETERS
// - DATA_WIDTH  8  width of every data word
// - NUM_CH      4  number of input channels, >= 2
// - CNT_WIDTH   8  width of the saturating contention counter
// PORTS
// - clk            in   1                    rising-edge clock
// - rst_n          in   1                    asynchronous, active-low reset
// - data_en        in   NUM_CH               per-channel request; held high with data until acked
// - data_in        in   NUM_CH*DATA_WIDTH    channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
// - data_ack       out  NUM_CH               one-hot, combinational; channel i's word is taken this cycle
// - data_out       out  DATA_WIDTH           registered output word
// - data_valid     out  1                    data_out holds an unconsumed word
// - data_ready     in   1                    consumer accepts data_out when data_valid && data_ready
// - contention_cnt out  CNT_WIDTH            saturating count of grant cycles with >1 enable asserted
// BEHAVIOUR
// - Reset (async assert, sync release): data_out=0, data_valid=0, contention_cnt=0, rr pointer=0. data_ack=0 while rst_n=0.
// - Output register FSM, two states:
//   EMPTY (data_valid=0) -> FULL on load.
//   FULL -> EMPTY on drain without load.
//   FULL stays FULL on drain+load, or on no drain.
// - load_ok = !data_valid || data_ready. Full throughput: one word per cycle when the consumer is always ready.
// - Grant: if load_ok and |data_en, grant the first channel with data_en set, searching from the pointer upward and wrapping at NUM_CH-1 -> 0.
// - A grant asserts data_ack[g] in the same cycle. On the next edge data_out <= word g and data_valid <= 1. Latency from request to data_valid: 1 clk.
// - Pointer update: only on a grant, pointer <= (g+1) mod NUM_CH. Otherwise it holds.
// - Without load_ok, no grant: data_ack=0, pointer holds, data_out holds. Backpressure must not drop or duplicate words.
// - Drain with no requests pending: data_valid <= 0. data_out keeps its last value; it does not return to 0.
// - Fairness: a channel that holds data_en high is granted within NUM_CH grants.
// - contention_cnt increments on each grant cycle where popcount(data_en) > 1. It saturates at all-ones and does not wrap.
// - Sources may change data_in only after seeing data_ack. Enables dropped before ack are simply not served.
// - Mid-operation reset: pending words are discarded and no ack is issued. After release, arbitration restarts from channel 0.
// STRUCTURE
// - Shared package buffer_pkg: default DATA_WIDTH/NUM_CH/CNT_WIDTH constants and a function for the ptr width, $clog2(NUM_CH).
// - Sub-module rr_arbiter #(NUM_CH).
//   Inputs: clk, rst_n, req[NUM_CH], advance.
//   Outputs: one-hot gnt, gnt_idx. The pointer register lives inside it.
// - Top level: the output register / FSM, the data mux indexed by gnt_idx, and the contention counter.
// TESTING
// - NUM_CH=2, en=2'b01, in1=0x01, ready=1 -> ack=01 same cycle; next clk data_out=0x01, valid=1.
// - en=2'b11, in={0x02,0x01}, ready=1 held -> grants alternate ch0,ch1,ch0. Output sequence 01,02,01. contention_cnt increments every cycle.
// - NUM_CH=4, all en=1, ready=0 after the first load -> valid=1 and data_out stable, ack=0. Releasing ready resumes in RR order with no lost word.
// - en=0 with ready=1 after the last word -> valid drops to 0 one clk after drain; data_out retains its last value.
// - CNT_WIDTH=2, contention held for 5 grants -> contention_cnt reaches 3 and stays at 3.
// - Assert rst_n=0 mid-stream with valid=1 -> valid, data_out and count clear immediately. After release, first grant goes to ch0 if requesting.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared defaults and helpers for the round-robin buffered output mux.
package buffer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int ptr_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping, and moves the pointer past the winner when told to advance.
module rr_arbiter
  import buffer_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int PW    = ptr_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [PW-1:0]     gnt_idx
);

  logic [PW-1:0] ptr;
  logic [PW:0]   cand;
  logic          found;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_CH)) cand = cand - (PW+1)'(NUM_CH);
      if (!found && req[cand[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
    gnt = found ? (NUM_CH'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      if (gnt_idx == PW'(NUM_CH - 1)) ptr <= '0;
      else                            ptr <= gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/buffer_rr_mux.sv
// N-channel request mux: round-robin arbitration into a single registered
// output word with valid/ready handshake and a saturating contention counter.
module buffer_rr_mux
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int PW        = ptr_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            data_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            data_ack,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic [CNT_WIDTH-1:0]         contention_cnt
);

  out_state_e          state;
  logic                load_ok;
  logic                grant;
  logic [NUM_CH-1:0]   gnt;
  logic [PW-1:0]       gnt_idx;
  logic [DATA_WIDTH-1:0] sel_word;

  assign data_valid = (state == ST_FULL);
  assign load_ok    = (state == ST_EMPTY) || data_ready;
  assign grant      = |gnt;
  // Ack is gated by reset so no source believes its word was taken mid-reset.
  assign data_ack   = gnt & {NUM_CH{rst_n}};

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (data_en & {NUM_CH{load_ok}}),
    .advance (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) sel_word = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A grant only happens when load_ok, so loading in FULL implies a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      data_out <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (grant) begin
            data_out <= sel_word;
            state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (grant)           data_out <= sel_word;
          else if (data_ready) state    <= ST_EMPTY;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_cnt <= '0;
    end else if (grant && ($countones(data_en) > 1) && (contention_cnt != '1)) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_buffer_rr_mux.sv
// Directed plus short random bench for buffer_rr_mux (4 channels, 2-bit counter)
// using a reference round-robin model and a word scoreboard.
module tb_buffer_rr_mux;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NC-1:0]    data_en;
  logic [NC*DW-1:0] data_in;
  logic [NC-1:0]    data_ack;
  logic [DW-1:0]    data_out;
  logic             data_valid;
  logic             data_ready;
  logic [CW-1:0]    contention_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] w [NC];
  logic [DW-1:0] sb [$];
  logic          m_valid;
  int            m_ptr;
  int            m_cnt;
  logic [DW-1:0] m_out;

  always #5 clk = ~clk;

  buffer_rr_mux #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_en        (data_en),
    .data_in        (data_in),
    .data_ack       (data_ack),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .contention_cnt (contention_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < NC; i++) data_in[i*DW +: DW] = w[i];
  endtask

  // One clock: check registered state, drive inputs, check ack and consumption, update model.
  task automatic cycle(input logic [NC-1:0] en, input logic rdy);
    logic          load_ok;
    logic [NC-1:0] exp_ack;
    logic [DW-1:0] expw;
    int            g;
    int            idx;
    @(negedge clk);
    chk("valid", 32'(data_valid), 32'(m_valid));
    chk("count", 32'(contention_cnt), 32'(m_cnt));
    chk("data_out_hold", 32'(data_out), 32'(m_out));
    data_en    = en;
    data_ready = rdy;
    pack_inputs();
    #1;
    load_ok = !m_valid || rdy;
    g = -1;
    if (load_ok) begin
      for (int k = 0; k < NC; k++) begin
        idx = (m_ptr + k) % NC;
        if (g < 0 && en[idx]) g = idx;
      end
    end
    exp_ack = (g >= 0) ? (NC'(1) << g) : '0;
    chk("ack", 32'(data_ack), 32'(exp_ack));
    if (m_valid && rdy) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 32'(0), 32'(1));
      end else begin
        expw = sb.pop_front();
        chk("consumed_word", 32'(data_out), 32'(expw));
      end
    end
    if (g >= 0) begin
      sb.push_back(w[g]);
      m_out   = w[g];
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NC;
      if ($countones(en) > 1 && m_cnt != 3) m_cnt++;
      w[g] = w[g] + 8'h10;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n   = 1'b0;
    data_en = '1;
    #1;
    chk("rst_ack", 32'(data_ack), 32'(0));
    chk("rst_valid", 32'(data_valid), 32'(0));
    chk("rst_data_out", 32'(data_out), 32'(0));
    chk("rst_count", 32'(contention_cnt), 32'(0));
    m_valid = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_out   = '0;
    sb.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    data_en = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    data_en    = '0;
    data_ready = 1'b0;
    for (int i = 0; i < NC; i++) w[i] = DW'(i + 1);
    pack_inputs();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_out   = '0;

    applyReset();

    // single request: same-cycle ack, one-cycle latency
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b1);

    // two-way contention alternates and saturates the 2-bit counter
    repeat (5) cycle(4'b0011, 1'b1);

    // backpressure with all channels requesting, then resume
    cycle(4'b1111, 1'b1);
    repeat (3) cycle(4'b1111, 1'b0);
    repeat (4) cycle(4'b1111, 1'b1);

    // drain with nothing pending; data_out keeps its last word
    repeat (2) cycle(4'b0000, 1'b1);

    // mid-stream reset, then arbitration restarts at channel 0
    cycle(4'b0110, 1'b1);
    applyReset();
    cycle(4'b1111, 1'b1);
    cycle(4'b1010, 1'b1);

    repeat (40) cycle(NC'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    repeat (3) cycle(4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
